// File: rtl/que_sched_arbiter.sv
// que_sched_arbiter
//
// Purpose:
//   Snapshot-based output-queue arbiter. On i_update it captures the pending
//   request bits and their priorities. It then serves that snapshot one port
//   at a time, highest priority first. Each grant is held on a valid/ready
//   handshake towards the downstream read controller.
//
// Build option:
//   QUE_SCHED_ARB_RR_EN
//     Defined: ties among equal-priority ports are broken round-robin. The
//       search starts at rr_ptr and wraps.
//     Undefined: ties go to the lowest port index and rr_ptr does not exist.
//
// Ports:
//   i_clk, i_rst_n  clock; asynchronous active-low reset
//   i_pending       request bit per port (sampled on i_update)
//   i_prior         priority of port k in bits [k*PRW +: PRW]
//   i_update        capture a new snapshot (honoured only in IDLE)
//   i_clr_port      port to withdraw from the snapshot
//   i_clr_vld       withdraw strobe
//   o_port          granted port
//   o_prior         priority of the granted port
//   o_port_vld      grant valid
//   i_port_rdy      grant accepted
//   o_empty         snapshot holds no pending ports
//   o_remain        number of pending ports in the snapshot
//   o_upd_drop      one-cycle pulse after an ignored i_update

module que_sched_arbiter #(
    parameter int PORTNUM = 16,
    parameter int PRIOR   = 8,
    parameter int PNW     = $clog2(PORTNUM),
    parameter int PRW     = $clog2(PRIOR)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [PORTNUM-1:0]             i_pending,
    input  logic [PORTNUM*PRW-1:0]         i_prior,
    input  logic                           i_update,
    input  logic [PNW-1:0]                 i_clr_port,
    input  logic                           i_clr_vld,
    output logic [PNW-1:0]                 o_port,
    output logic [PRW-1:0]                 o_prior,
    output logic                           o_port_vld,
    input  logic                           i_port_rdy,
    output logic                           o_empty,
    output logic [$clog2(PORTNUM+1)-1:0]   o_remain,
    output logic                           o_upd_drop
);

    localparam int CNW = $clog2(PORTNUM+1);
    // One bit wider than a port index, so that PORTNUM itself is
    // representable when the port count is a power of two.
    localparam logic [PNW:0] PORT_LIM = (PNW+1)'(PORTNUM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        GRANT = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [PORTNUM-1:0]   pend;
    logic [PORTNUM-1:0]   pend_nxt;
    logic [PRW-1:0]       prio [PORTNUM];
    logic                 capture;

    logic [PNW-1:0]       port_nxt;
    logic [PRW-1:0]       prior_nxt;
    logic                 vld_nxt;
    logic                 drop_nxt;

    logic                 clr_ok;
    logic [PORTNUM-1:0]   clr_mask;
    logic [PORTNUM-1:0]   grant_mask;
    logic [PORTNUM-1:0]   pend_arb;
    logic                 handshake;
    logic                 clr_hits_grant;

    logic [PRW-1:0]       max_prio;
    logic [PORTNUM-1:0]   cand;
    logic [PNW-1:0]       win_lo;
    logic [PNW-1:0]       winner;
    logic [CNW-1:0]       count;

`ifdef QUE_SCHED_ARB_RR_EN
    logic [PNW-1:0]       rr_ptr;
    logic [PNW-1:0]       rr_nxt;
    logic [PNW-1:0]       win_hi;
    logic                 hi_found;
`endif

    // Decode the withdraw strobe and the current grant into one-hot masks.
    // Out-of-range withdraw ports produce an empty mask.
    always_comb begin
        clr_ok     = i_clr_vld && ({1'b0, i_clr_port} < PORT_LIM);
        clr_mask   = '0;
        grant_mask = '0;
        for (int k = 0; k < PORTNUM; k++) begin
            clr_mask[k]   = clr_ok && (i_clr_port == PNW'(k));
            grant_mask[k] = (o_port == PNW'(k));
        end
        handshake      = (state == GRANT) && o_port_vld && i_port_rdy;
        clr_hits_grant = clr_ok && (i_clr_port == o_port);
        // Arbitration sees a withdraw of the same cycle, so a port cleared
        // in ARB can never be granted.
        pend_arb       = pend & ~clr_mask;
    end

    // Winner search. First find the highest priority among the pending
    // ports, then break ties between the ports that hold that priority.
    always_comb begin
        max_prio = '0;
        cand     = '0;
        win_lo   = '0;
        for (int k = 0; k < PORTNUM; k++) begin
            if (pend_arb[k] && (prio[k] > max_prio)) begin
                max_prio = prio[k];
            end
        end
        for (int k = 0; k < PORTNUM; k++) begin
            cand[k] = pend_arb[k] && (prio[k] == max_prio);
        end
        // Scanning downwards leaves the lowest matching index.
        for (int k = PORTNUM-1; k >= 0; k--) begin
            if (cand[k]) begin
                win_lo = PNW'(k);
            end
        end
`ifdef QUE_SCHED_ARB_RR_EN
        win_hi   = '0;
        hi_found = 1'b0;
        for (int k = PORTNUM-1; k >= 0; k--) begin
            if (cand[k] && (PNW'(k) >= rr_ptr)) begin
                win_hi   = PNW'(k);
                hi_found = 1'b1;
            end
        end
        // Nothing at or above the pointer: wrap to the lowest candidate.
        winner = hi_found ? win_hi : win_lo;
`else
        winner = win_lo;
`endif
    end

    // Occupancy status is taken directly from the snapshot register.
    always_comb begin
        count = '0;
        for (int k = 0; k < PORTNUM; k++) begin
            count = count + CNW'(pend[k]);
        end
    end

    assign o_empty  = ~|pend;
    assign o_remain = count;

    // Next-state and next-output logic for the IDLE/ARB/GRANT controller.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend & ~clr_mask;
        capture   = 1'b0;
        port_nxt  = o_port;
        prior_nxt = o_prior;
        vld_nxt   = o_port_vld;
        drop_nxt  = i_update && (state != IDLE);
`ifdef QUE_SCHED_ARB_RR_EN
        rr_nxt    = rr_ptr;
`endif
        case (state)
            IDLE: begin
                // A snapshot capture takes priority over a withdraw
                // in the same cycle.
                if (i_update && (|i_pending)) begin
                    capture   = 1'b1;
                    pend_nxt  = i_pending;
                    state_nxt = ARB;
                end
            end
            ARB: begin
                if (pend_arb == '0) begin
                    state_nxt = IDLE;
                end else begin
                    port_nxt  = winner;
                    prior_nxt = prio[winner];
                    vld_nxt   = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (handshake) begin
                    // A withdraw on the granted port in this cycle
                    // collapses into the handshake. A withdraw on another
                    // port is applied alongside it.
                    pend_nxt  = pend & ~clr_mask & ~grant_mask;
                    vld_nxt   = 1'b0;
                    state_nxt = (|(pend & ~clr_mask & ~grant_mask)) ? ARB : IDLE;
`ifdef QUE_SCHED_ARB_RR_EN
                    rr_nxt    = (o_port == PNW'(PORTNUM-1)) ? '0 : o_port + PNW'(1);
`endif
                end else if (clr_hits_grant) begin
                    vld_nxt   = 1'b0;
                    state_nxt = ARB;
                end
            end
            default: begin
                state_nxt = IDLE;
                vld_nxt   = 1'b0;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Snapshot, grant and pulse registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend       <= '0;
            o_port     <= '0;
            o_prior    <= '0;
            o_port_vld <= 1'b0;
            o_upd_drop <= 1'b0;
            for (int k = 0; k < PORTNUM; k++) begin
                prio[k] <= '0;
            end
        end else begin
            pend       <= pend_nxt;
            o_port     <= port_nxt;
            o_prior    <= prior_nxt;
            o_port_vld <= vld_nxt;
            o_upd_drop <= drop_nxt;
            if (capture) begin
                for (int k = 0; k < PORTNUM; k++) begin
                    prio[k] <= i_prior[k*PRW +: PRW];
                end
            end
        end
    end

`ifdef QUE_SCHED_ARB_RR_EN
    // Round-robin pointer. It points one past the last accepted port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_que_sched_arbiter.sv
// tb_que_sched_arbiter
//
// Purpose:
//   Self-checking bench for que_sched_arbiter at PORTNUM=16 and PRIOR=8.
//   A table of snapshots feeds a scoreboard of the expected grants, which is
//   compared against every handshake. Hand-written sequences cover
//   backpressure, withdraw, dropped updates, combined clear and handshake,
//   and reset in the middle of operation.
//   QUE_SCHED_ARB_RR_EN selects the tie-break expectations.

module tb_que_sched_arbiter;

    localparam int PORTNUM = 16;
    localparam int PRIOR   = 8;
    localparam int PNW     = 4;
    localparam int PRW     = 3;
    localparam int CNW     = 5;
    localparam int NVEC    = 7;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [PORTNUM-1:0]     pending;
    logic [PORTNUM*PRW-1:0] prior;
    logic                   update;
    logic [PNW-1:0]         clr_port;
    logic                   clr_vld;
    logic [PNW-1:0]         port;
    logic [PRW-1:0]         gprior;
    logic                   port_vld;
    logic                   port_rdy;
    logic                   empty;
    logic [CNW-1:0]         remain;
    logic                   upd_drop;

    always #5 clk = ~clk;

    que_sched_arbiter #(
        .PORTNUM (PORTNUM),
        .PRIOR   (PRIOR)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_pending  (pending),
        .i_prior    (prior),
        .i_update   (update),
        .i_clr_port (clr_port),
        .i_clr_vld  (clr_vld),
        .o_port     (port),
        .o_prior    (gprior),
        .o_port_vld (port_vld),
        .i_port_rdy (port_rdy),
        .o_empty    (empty),
        .o_remain   (remain),
        .o_upd_drop (upd_drop)
    );

    typedef struct {
        logic [PORTNUM-1:0]     pend;
        logic [PORTNUM*PRW-1:0] pri;
        int                     n;
        int                     order [4];
    } vec_t;

    typedef struct {
        logic [PNW-1:0] port;
        logic [PRW-1:0] pri;
    } exp_t;

    vec_t vecs [NVEC];
    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;

    // Returns a priority vector with one port's field replaced.
    function automatic logic [PORTNUM*PRW-1:0] setp(input logic [PORTNUM*PRW-1:0] base,
                                                     input int p, input int v);
        logic [PORTNUM*PRW-1:0] r;
        r = base;
        r[p*PRW +: PRW] = PRW'(v);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drives one table snapshot and queues its expected grants.
    task automatic applyStimulus(input int idx);
        exp_t e;
        @(negedge clk);
        pending = vecs[idx].pend;
        prior   = vecs[idx].pri;
        update  = 1'b1;
        for (int j = 0; j < vecs[idx].n; j++) begin
            e.port = PNW'(vecs[idx].order[j]);
            e.pri  = vecs[idx].pri[vecs[idx].order[j]*PRW +: PRW];
            sb.push_back(e);
        end
        @(negedge clk);
        update = 1'b0;
        checkOutput("empty_after_update", 32'(empty), 32'd0);
        checkOutput("remain_after_update", 32'(remain), 32'($countones(vecs[idx].pend)));
    endtask

    // Accepts every grant and pops the scoreboard on each handshake.
    task automatic runGrants(input int budget);
        int   cyc = 0;
        bit   first = 1'b1;
        bit   prev_hs = 1'b0;
        exp_t e;
        port_rdy = 1'b1;
        while (((sb.size() > 0) || port_vld) && (cyc < budget)) begin
            @(negedge clk);
            cyc++;
            if (first) begin
                checkOutput("grant_latency", 32'(port_vld), 32'd1);
                first = 1'b0;
            end
            if (prev_hs) begin
                checkOutput("vld_one_cycle", 32'(port_vld), 32'd0);
            end
            prev_hs = 1'b0;
            if (port_vld) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_grant", 32'(port), 32'hFFFF);
                end else begin
                    e = sb.pop_front();
                    checkOutput("grant_port", 32'(port), 32'(e.port));
                    checkOutput("grant_prior", 32'(gprior), 32'(e.pri));
                end
                prev_hs = 1'b1;
            end
        end
        if (sb.size() != 0) begin
            checkOutput("grant_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
        port_rdy = 1'b0;
        checkOutput("empty_after_drain", 32'(empty), 32'd1);
        checkOutput("remain_after_drain", 32'(remain), 32'd0);
        checkOutput("vld_after_drain", 32'(port_vld), 32'd0);
    endtask

    initial begin
        logic [PORTNUM*PRW-1:0] hi;
        logic [PORTNUM*PRW-1:0] p;
        exp_t e;
        int   w;

        // Ports that are not pending carry priority 7, so any leak from a
        // non-pending port would steal the grant.
        hi = {PORTNUM{3'd7}};

        vecs[0].pend = 16'h0013;
        vecs[0].pri  = setp(setp(setp(hi, 0, 2), 1, 7), 4, 7);
        vecs[0].n    = 3;
        vecs[0].order = '{1, 4, 0, 0};
        for (int i = 1; i <= 3; i++) begin
            vecs[i].pend  = 16'h0224;
            vecs[i].pri   = setp(setp(setp(hi, 2, 3), 5, 3), 9, 3);
            vecs[i].n     = 3;
            vecs[i].order = '{2, 5, 9, 0};
        end
        vecs[4].pend  = 16'h0020;
        vecs[4].pri   = setp(hi, 5, 3);
        vecs[4].n     = 1;
        vecs[4].order = '{5, 0, 0, 0};
        vecs[5].pend  = 16'h0204;
        vecs[5].pri   = setp(setp(hi, 2, 3), 9, 3);
        vecs[5].n     = 2;
`ifdef QUE_SCHED_ARB_RR_EN
        vecs[5].order = '{9, 2, 0, 0};
`else
        vecs[5].order = '{2, 9, 0, 0};
`endif
        vecs[6].pend  = 16'h8421;
        vecs[6].pri   = setp(setp(setp(setp(hi, 0, 1), 5, 6), 10, 3), 15, 6);
        vecs[6].n     = 4;
        vecs[6].order = '{5, 15, 10, 0};

        rst_n    = 1'b0;
        pending  = '0;
        prior    = '0;
        update   = 1'b0;
        clr_port = '0;
        clr_vld  = 1'b0;
        port_rdy = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_port", 32'(port), 32'd0);
        checkOutput("reset_prior", 32'(gprior), 32'd0);
        checkOutput("reset_vld", 32'(port_vld), 32'd0);
        checkOutput("reset_empty", 32'(empty), 32'd1);
        checkOutput("reset_remain", 32'(remain), 32'd0);
        checkOutput("reset_drop", 32'(upd_drop), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(i);
            runGrants(40);
        end

        // Backpressure, then withdraw of the held grant.
        p = setp(setp(setp(setp(hi, 3, 6), 6, 5), 8, 1), 10, 0);
        @(negedge clk);
        pending  = 16'h0548;
        prior    = p;
        update   = 1'b1;
        port_rdy = 1'b0;
        @(negedge clk);
        update = 1'b0;
        w = 0;
        while (!port_vld && (w < 10)) begin
            @(negedge clk);
            w++;
        end
        checkOutput("bp_first_vld", 32'(port_vld), 32'd1);
        checkOutput("bp_first_port", 32'(port), 32'd3);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("bp_hold_port", 32'(port), 32'd3);
            checkOutput("bp_hold_prior", 32'(gprior), 32'd6);
            checkOutput("bp_hold_vld", 32'(port_vld), 32'd1);
        end
        clr_vld  = 1'b1;
        clr_port = 4'd3;
        @(negedge clk);
        clr_vld = 1'b0;
        checkOutput("withdraw_vld", 32'(port_vld), 32'd0);
        checkOutput("withdraw_remain", 32'(remain), 32'd3);
        @(negedge clk);
        checkOutput("regrant_vld", 32'(port_vld), 32'd1);
        checkOutput("regrant_port", 32'(port), 32'd6);
        checkOutput("regrant_prior", 32'(gprior), 32'd5);

        // i_update while a grant is outstanding is dropped.
        update  = 1'b1;
        pending = 16'hFFFF;
        @(negedge clk);
        update = 1'b0;
        checkOutput("drop_pulse", 32'(upd_drop), 32'd1);
        checkOutput("drop_remain", 32'(remain), 32'd3);
        checkOutput("drop_port", 32'(port), 32'd6);
        @(negedge clk);
        checkOutput("drop_pulse_end", 32'(upd_drop), 32'd0);
        checkOutput("drop_remain2", 32'(remain), 32'd3);

        // Clear and handshake on the same port count as one handshake.
        clr_vld  = 1'b1;
        clr_port = 4'd6;
        port_rdy = 1'b1;
        @(negedge clk);
        clr_vld  = 1'b0;
        port_rdy = 1'b0;
        checkOutput("same_clr_remain", 32'(remain), 32'd2);
        checkOutput("same_clr_vld", 32'(port_vld), 32'd0);
        @(negedge clk);
        checkOutput("next_port", 32'(port), 32'd8);
        checkOutput("next_prior", 32'(gprior), 32'd1);
        checkOutput("next_vld", 32'(port_vld), 32'd1);

        // Clear and handshake on different ports clear both bits.
        clr_vld  = 1'b1;
        clr_port = 4'd10;
        port_rdy = 1'b1;
        @(negedge clk);
        clr_vld  = 1'b0;
        port_rdy = 1'b0;
        checkOutput("diff_clr_remain", 32'(remain), 32'd0);
        checkOutput("diff_clr_empty", 32'(empty), 32'd1);
        @(negedge clk);
        checkOutput("diff_clr_no_grant", 32'(port_vld), 32'd0);

        // i_update with nothing pending in IDLE does nothing.
        update  = 1'b1;
        pending = '0;
        @(negedge clk);
        update = 1'b0;
        checkOutput("zero_upd_empty", 32'(empty), 32'd1);
        checkOutput("zero_upd_drop", 32'(upd_drop), 32'd0);

        // i_update wins over a same-cycle clear in IDLE.
        update   = 1'b1;
        pending  = 16'h0003;
        prior    = '0;
        clr_vld  = 1'b1;
        clr_port = 4'd0;
        e.port = 4'd0; e.pri = 3'd0; sb.push_back(e);
        e.port = 4'd1; e.pri = 3'd0; sb.push_back(e);
        @(negedge clk);
        update  = 1'b0;
        clr_vld = 1'b0;
        checkOutput("upd_beats_clr", 32'(remain), 32'd2);
        runGrants(20);

        // Reset in the middle of a grant discards everything at once.
        @(negedge clk);
        pending = 16'h0030;
        prior   = setp(setp('0, 4, 2), 5, 1);
        update  = 1'b1;
        @(negedge clk);
        update = 1'b0;
        @(negedge clk);
        checkOutput("pre_reset_vld", 32'(port_vld), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_vld", 32'(port_vld), 32'd0);
        checkOutput("async_reset_empty", 32'(empty), 32'd1);
        checkOutput("async_reset_remain", 32'(remain), 32'd0);
        checkOutput("async_reset_port", 32'(port), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_vld", 32'(port_vld), 32'd0);
        checkOutput("post_reset_empty", 32'(empty), 32'd1);

        applyStimulus(0);
        runGrants(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/que_sched_arbiter.md
# que_sched_arbiter

Parametrised successor to the 16-port queue arbitrator. It latches a snapshot of pending output-queue requests and their priorities, then serves the snapshot one port at a time: highest priority first, round-robin among equal priorities. Each grant is held under a valid/ready handshake to the downstream read controller. It sits between the per-port queue status logic and the cache read scheduler, for any port count and priority depth.

## Interface
- `PORTNUM`, 16: number of ports, ≥2.
- `PRIOR`, 8: number of priority levels, ≥2. Level `PRIOR-1` is the highest, 0 the lowest.
- `PNW`, `$clog2(PORTNUM)`: derived port index width.
- `PRW`, `$clog2(PRIOR)`: derived priority width.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_pending`, in, `PORTNUM`: request bit per port.
- `i_prior`, in, `PORTNUM*PRW`: priority of port k in bits `[k*PRW +: PRW]`.
- `i_update`, in, 1: capture a snapshot.
- `i_clr_port`, in, `PNW`: port to withdraw.
- `i_clr_vld`, in, 1: withdraw strobe.
- `o_port`, out, `PNW`: granted port.
- `o_prior`, out, `PRW`: priority of the granted port.
- `o_port_vld`, out, 1: grant valid.
- `i_port_rdy`, in, 1: grant accepted.
- `o_empty`, out, 1: snapshot has no pending ports.
- `o_remain`, out, `$clog2(PORTNUM+1)`: pending count in the snapshot.
- `o_upd_drop`, out, 1: one-cycle pulse when `i_update` is ignored.

## Operation
- Registered state: `pend[PORTNUM]`, `prio[PORTNUM]`, `rr_ptr[PNW]`, and FSM states IDLE / ARB / GRANT.
- **IDLE**
  - `o_empty`=1.
  - `i_update` with `i_pending`≠0: capture `pend`/`prio`, go to ARB.
  - `i_update` with `i_pending`=0: no change, no drop pulse.
- **ARB** (exactly one cycle)
  - Winner = the pending port with maximum `prio`. Ties are broken per Configuration.
  - Register the winner into `o_port`/`o_prior` and set `o_port_vld`=1. Go to GRANT.
  - If `pend` is 0 on entry (cleared by `i_clr_vld`), go to IDLE with no grant.
- **GRANT**
  - `o_port`, `o_prior` and `o_port_vld` are held stable until `i_port_rdy`=1.
  - On handshake: clear `pend[o_port]`, set `rr_ptr` to `(o_port+1) mod PORTNUM`, drop `o_port_vld`. Go to ARB if other bits remain, else IDLE.
- **`i_update` outside IDLE**: ignored; `o_upd_drop` pulses the next cycle.
- **`i_clr_vld`** (any state): clear `pend[i_clr_port]`.
  - In GRANT with `i_clr_port`==`o_port` and no handshake: the grant is withdrawn. `o_port_vld`=0 next cycle, go to ARB.
  - Clear and handshake on the same port in the same cycle: counts as one handshake.
  - Clear and handshake on different ports: both bits cleared.
  - `i_clr_vld` with `i_update` in IDLE: the update wins and the clear is ignored.
- `o_empty` = ~|`pend`. `o_remain` = popcount(`pend`). Both are combinational from registers.
- Out-of-range `i_clr_port` (≥`PORTNUM`) is ignored.

## Timing
- Reset values: `pend`=0, `prio`=0, `rr_ptr`=0, state IDLE, `o_port`=0, `o_prior`=0, `o_port_vld`=0, `o_empty`=1, `o_remain`=0, `o_upd_drop`=0.
- `i_update` at cycle T: `o_empty`=0 and state ARB at T+1, `o_port_vld`=1 at T+2.
- Handshake at T: `o_remain` decrements at T+1, next `o_port_vld` at T+2. Throughput is one grant per 2 cycles.
- Reset asserted mid-operation: all state returns to reset values immediately, and any outstanding grant is lost.

## Configuration
- `QUE_SCHED_ARB_RR_EN` defined: ties among equal-priority winners go to the first pending index ≥ `rr_ptr`, searching cyclically.
- Not defined: ties go to the lowest index. `rr_ptr` is not implemented.

## Test plan
- **Reset.** Hold `i_rst_n`=0 for 3 cycles → all outputs at their reset values, `o_empty`=1.
- **Priority order.** `PORTNUM`=16, `PRIOR`=8, `i_pending`=0x0013; port0 prio 2, port1 prio 7, port4 prio 7; `i_port_rdy`=1 throughout. Required grant order:
  - with RR: 1, 4, 0;
  - without RR: 1, 4, 0.
  - Then `o_empty`=1 and each `o_port_vld` lasts 1 cycle.
- **Round-robin.** RR build, 3 consecutive snapshots of ports {2, 5, 9}, all at prio 3. Required grants:
  - snapshot 1: 2, 5, 9;
  - snapshot 2: 2, 5, 9, because `rr_ptr` wraps from 10 to 2.
  - Separately, preload `rr_ptr`=6 via a prior grant of port 5 → the next tie picks 9.
- **Backpressure and withdraw.** Hold `i_port_rdy`=0 for 5 cycles → `o_port`/`o_prior` stable. Then assert `i_clr_vld` on `o_port` → `o_port_vld`=0 next cycle, the next pending port is granted 2 cycles later, and `o_remain` drops by 1.
- **Dropped update.** `i_update` in GRANT → `o_upd_drop`=1 for one cycle and the snapshot is unchanged. Same-cycle clear and handshake on the same port → `o_remain` decrements by exactly 1.
